// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS sequencing controller and ALU control.
package mips_multicycle_ctrl_pkg;

  // State encodings, visible on the State output
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_TRAP      = 3'd5;
  localparam logic [2:0] ST_HALT      = 3'd6;

  typedef enum logic [2:0] {
    StIdle      = ST_IDLE,
    StFetch     = ST_FETCH,
    StDecode    = ST_DECODE,
    StExecute   = ST_EXECUTE,
    StWriteback = ST_WRITEBACK,
    StTrap      = ST_TRAP,
    StHalt      = ST_HALT
  } state_e;

  // R-type funct codes supported by the datapath
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  // ALUOp encodings handed to ALU control
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;

endpackage

// File: rtl/mips_multicycle_ctrl_funct_legal.sv
// Combinational check: is this funct one of the R-type operations the datapath implements?
module mips_funct_legal
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic       legal
);

  // Match against the supported funct set
  always_comb begin
    legal = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle sequencing controller: FETCH/DECODE/EXECUTE/WRITEBACK with trap, halt and
// a saturating retired-instruction counter. All outputs are registered from the next state.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES  = 1,
  parameter logic [5:0]  RTYPE_OP     = 6'h00,
  parameter bit          CHECK_OPCODE = 1'b0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             Run,
  input  logic [31:0]      INSTRUCTION,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic [2:0]       State,
  output logic             Halted,
  output logic             IllegalFunct,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [3:0] ExecLast = 4'(EXEC_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] opcode_q;
  logic [5:0] funct_q;
  logic       instr_zero_q;
  logic [3:0] exec_cnt_q;
  logic       funct_ok;

  mips_funct_legal u_funct_legal (
    .funct (funct_q),
    .legal (funct_ok)
  );

  assign State = state_q;

  // Next-state decode; Run only matters in IDLE, WRITEBACK and TRAP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (Run) state_d = StFetch;
      StFetch:     state_d = StDecode;
      StDecode: begin
        if (instr_zero_q) begin
          state_d = StHalt;
        end else if (CHECK_OPCODE && (opcode_q != RTYPE_OP)) begin
          state_d = StTrap;
        end else if (!funct_ok) begin
          state_d = StTrap;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute:   if (exec_cnt_q == ExecLast) state_d = StWriteback;
      StWriteback: state_d = Run ? StFetch : StIdle;
      StTrap:      state_d = Run ? StFetch : StIdle;
      StHalt:      state_d = StHalt;
      default:     state_d = StIdle;
    endcase
  end

  // State, decode latches, exec counter and Moore outputs registered from the next state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      opcode_q     <= '0;
      funct_q      <= '0;
      instr_zero_q <= 1'b0;
      exec_cnt_q   <= '0;
      PCWrite      <= 1'b0;
      IRWrite      <= 1'b0;
      ALUOp        <= ALUOP_ADD;
      RegWrite     <= 1'b0;
      Halted       <= 1'b0;
      IllegalFunct <= 1'b0;
      InstrCount   <= '0;
    end else begin
      state_q <= state_d;

      // The word is valid through FETCH/DECODE; capture it as the IR loads so
      // DECODE decides from stable registered fields
      if (state_q == StFetch) begin
        opcode_q     <= INSTRUCTION[31:26];
        funct_q      <= INSTRUCTION[5:0];
        instr_zero_q <= (INSTRUCTION == 32'h0);
      end

      // Zero on EXECUTE entry, count while staying
      if ((state_q == StExecute) && (state_d == StExecute)) begin
        exec_cnt_q <= exec_cnt_q + 4'd1;
      end else begin
        exec_cnt_q <= '0;
      end

      IRWrite      <= (state_d == StFetch);
      PCWrite      <= (state_d == StWriteback) || (state_d == StTrap);
      RegWrite     <= (state_d == StWriteback);
      IllegalFunct <= (state_d == StTrap);
      ALUOp        <= ((state_d == StExecute) || (state_d == StWriteback)) ? ALUOP_RTYPE
                                                                           : ALUOP_ADD;
      if (state_d == StHalt) Halted <= 1'b1;

      // Retire on WRITEBACK entry, saturating at all-ones
      if ((state_d == StWriteback) && (InstrCount != '1)) begin
        InstrCount <= InstrCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: default controller, a slow/narrow-counter/opcode-checking variant, and
// an exhaustive sweep of the funct legality checker.
module tb_mips_multicycle_ctrl;

  logic        CLK;
  int          checks = 0;
  int          errors = 0;

  // Instance 0: default parameters
  logic        rst0_n, run0;
  logic [31:0] instr0;
  logic        pcw0, irw0, rw0, halt0, ill0;
  logic [1:0]  aluop0;
  logic [2:0]  st0;
  logic [15:0] cnt0;

  // Instance 1: EXEC_CYCLES=3, CNT_W=2, opcode checked
  logic        rst1_n, run1;
  logic [31:0] instr1;
  logic        pcw1, irw1, rw1, halt1, ill1;
  logic [1:0]  aluop1;
  logic [2:0]  st1;
  logic [1:0]  cnt1;

  logic [5:0]  fn_in;
  logic        fn_legal;

  mips_multicycle_ctrl dut0 (
    .CLK          (CLK),
    .RESET_N      (rst0_n),
    .Run          (run0),
    .INSTRUCTION  (instr0),
    .PCWrite      (pcw0),
    .IRWrite      (irw0),
    .ALUOp        (aluop0),
    .RegWrite     (rw0),
    .State        (st0),
    .Halted       (halt0),
    .IllegalFunct (ill0),
    .InstrCount   (cnt0)
  );

  mips_multicycle_ctrl #(
    .EXEC_CYCLES  (3),
    .RTYPE_OP     (6'h00),
    .CHECK_OPCODE (1'b1),
    .CNT_W        (2)
  ) dut1 (
    .CLK          (CLK),
    .RESET_N      (rst1_n),
    .Run          (run1),
    .INSTRUCTION  (instr1),
    .PCWrite      (pcw1),
    .IRWrite      (irw1),
    .ALUOp        (aluop1),
    .RegWrite     (rw1),
    .State        (st1),
    .Halted       (halt1),
    .IllegalFunct (ill1),
    .InstrCount   (cnt1)
  );

  mips_funct_legal u_fl (
    .funct (fn_in),
    .legal (fn_legal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0_n = 1'b0; run0 = 1'b0; instr0 = 32'h08011020;
    rst1_n = 1'b0; run1 = 1'b0; instr1 = 32'h0000002A;
    fn_in  = 6'd0;
    tick();
    tick();

    // ---------------- instance 0 ----------------
    check("rst_state", 32'(st0), 0);
    check("rst_strobes", 32'({pcw0, irw0, rw0, ill0, halt0}), 0);
    check("rst_aluop", 32'(aluop0), 0);
    check("rst_count", 32'(cnt0), 0);

    rst0_n = 1'b1; run0 = 1'b1;
    tick();  // cycle 1
    check("c1_state", 32'(st0), 1);
    check("c1_irwrite", 32'(irw0), 1);
    tick();  // cycle 2
    check("c2_state_irw", 32'({st0, irw0}), 32'h4);
    tick();  // cycle 3
    check("c3_state", 32'(st0), 3);
    check("c3_aluop", 32'(aluop0), 2);
    check("c3_regwrite", 32'(rw0), 0);
    tick();  // cycle 4
    check("c4_state", 32'(st0), 4);
    check("c4_rw_pcw_irw", 32'({rw0, pcw0, irw0}), 32'h6);
    check("c4_aluop", 32'(aluop0), 2);
    check("c4_count", 32'(cnt0), 1);
    tick();  // cycle 5
    check("c5_state", 32'(st0), 1);
    check("c5_irw_rw", 32'({irw0, rw0}), 32'h2);

    // OR (funct 37) retires, then funct 3F traps
    instr0 = 32'h00000025;
    tick(); tick(); tick();
    check("or_wb_state", 32'(st0), 4);
    check("or_count", 32'(cnt0), 2);
    instr0 = 32'h0000003F;
    tick(); tick(); tick();
    check("trap_state", 32'(st0), 5);
    check("trap_ill_pcw_rw", 32'({ill0, pcw0, rw0}), 32'h6);
    check("trap_count", 32'(cnt0), 2);
    tick();
    check("trap_pulse_end", 32'({st0, ill0}), 32'h2);

    // Run dropped during EXECUTE: instruction still completes, then IDLE
    instr0 = 32'h0000002A;
    tick(); tick();
    check("drop_exec_state", 32'(st0), 3);
    run0 = 1'b0;
    tick();
    check("drop_wb_rw", 32'({st0, rw0}), 32'h9);
    check("drop_count", 32'(cnt0), 3);
    tick();
    check("drop_idle", 32'(st0), 0);
    tick();
    check("drop_idle_no_irw", 32'({st0, irw0}), 0);

    // Halt on all-zero word; sticky against Run toggling
    instr0 = 32'h0; run0 = 1'b1;
    tick(); tick(); tick();
    check("halt_state", 32'(st0), 6);
    check("halt_flag", 32'(halt0), 1);
    for (int i = 0; i < 10; i++) begin
      run0 = i[0];
      tick();
      check("halt_hold", 32'({halt0, irw0, pcw0, rw0, ill0, st0}), 32'h86);
    end
    rst0_n = 1'b0;
    #1;
    check("halt_reset", 32'({halt0, st0}), 0);
    check("halt_reset_cnt", 32'(cnt0), 0);

    // Async reset between edges while in EXECUTE drops the pending writeback
    tick();
    rst0_n = 1'b1; run0 = 1'b1; instr0 = 32'h00000020;
    tick(); tick(); tick();
    check("ar_exec_state", 32'(st0), 3);
    #3;
    rst0_n = 1'b0;
    #1;
    check("ar_immediate", 32'({aluop0, st0}), 0);
    run0 = 1'b0;
    rst0_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ar_no_wb", 32'({rw0, pcw0, st0}), 0);
    end

    // ---------------- instance 1 ----------------
    rst1_n = 1'b1; run1 = 1'b1; instr1 = 32'h0000002A;
    tick();
    check("x3_fetch", 32'(st1), 1);
    tick();
    check("x3_decode", 32'({aluop1, st1}), 32'h02);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("x3_exec", 32'({aluop1, st1, rw1}), 32'h26);
    end
    tick();  // cycle 6
    check("x3_wb", 32'({st1, rw1, pcw1}), 32'h13);
    check("x3_count", 32'(cnt1), 1);
    instr1 = 32'h0400002A;  // opcode 1 with legal funct
    tick();  // cycle 7
    check("x3_refetch", 32'({st1, irw1}), 32'h3);
    tick(); tick();
    check("op_trap", 32'({st1, ill1, rw1}), 32'h16);
    check("op_trap_count", 32'(cnt1), 1);
    tick();
    instr1 = 32'h00000020;
    for (int k = 0; k < 5; k++) begin
      repeat (5) tick();
      check("sat_wb_state", 32'(st1), 4);
      check("sat_count", 32'(cnt1), (k == 0) ? 2 : 3);
      tick();
    end

    // ---------------- funct legality sweep ----------------
    for (int i = 0; i < 64; i++) begin
      fn_in = 6'(i);
      #1;
      check("funct_legal", 32'(fn_legal),
            (i == 32 || i == 34 || i == 36 || i == 37 || i == 39 || i == 42) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle sequencing controller placed between the instruction register and ALU control.
- Decodes the fetched instruction word and steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
- Drives the PC update, IR load, ALUOp and register-file write strobes for the R-type datapath (ADD/SUB/AND/OR/NOR/SLT).
- Detects halt and illegal-funct instructions and keeps a retired-instruction count.

Parameters:
- EXEC_CYCLES, 1: cycles spent in EXECUTE, range 1..15.
- RTYPE_OP, 6'h00: opcode accepted as R-type when CHECK_OPCODE=1.
- CHECK_OPCODE, 0: 1 means any opcode other than RTYPE_OP traps; 0 means the opcode is ignored.
- CNT_W, 16: width of InstrCount.

Ports:
- CLK, input, 1: clock, rising-edge active.
- RESET_N, input, 1: asynchronous active-low reset.
- Run, input, 1: level; 1 allows instruction issue.
- INSTRUCTION, input, 32: word from instruction memory; valid while in FETCH/DECODE.
- PCWrite, output, 1: PC load strobe (PC += 4).
- IRWrite, output, 1: instruction register load strobe.
- ALUOp, output, 2: 2'b10 means R-type, use funct; 2'b00 otherwise.
- RegWrite, output, 1: register-file write enable.
- State, output, 3: current state encoding.
- Halted, output, 1: sticky halt flag.
- IllegalFunct, output, 1: one-cycle pulse on trap.
- InstrCount, output, CNT_W: retired-instruction count.

Behaviour:
- Reset: asynchronous on RESET_N=0. State=IDLE; PCWrite, IRWrite, RegWrite, IllegalFunct, Halted = 0; ALUOp=2'b00; InstrCount=0; exec counter=0.
- All outputs are registered and reflect the current state only (Moore). No combinational input-to-output path.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, TRAP=5, HALT=6.
- IDLE: all strobes 0. Go to FETCH when Run=1, otherwise stay.
- FETCH: IRWrite=1 for exactly one cycle. Always go to DECODE.
- DECODE: latch INSTRUCTION[31:26] and INSTRUCTION[5:0] internally. Priority order:
  - INSTRUCTION==32'h0 → HALT.
  - CHECK_OPCODE=1 and opcode≠RTYPE_OP → TRAP.
  - funct not in {32,34,36,37,39,42} → TRAP.
  - otherwise → EXECUTE.
- EXECUTE: ALUOp=2'b10 on every EXECUTE cycle. Exec counter loads 0 on entry and increments each cycle. Leave for WRITEBACK after exactly EXEC_CYCLES cycles.
- WRITEBACK: RegWrite=1 and PCWrite=1 for one cycle; ALUOp stays 2'b10. InstrCount increments and saturates at all-ones with no wrap. Next state is FETCH if Run=1, else IDLE.
- TRAP: IllegalFunct=1 and PCWrite=1 for one cycle; RegWrite=0; InstrCount unchanged. Next state is FETCH if Run=1, else IDLE.
- HALT: Halted=1 and all strobes 0. Stays in HALT regardless of Run; only reset exits.
- Latency: a legal instruction takes 3+EXEC_CYCLES cycles from FETCH entry to WRITEBACK exit (default 4). A trap takes 3 cycles; a halt takes 2 cycles to reach HALT.
- Run deasserted mid-instruction: the current instruction always completes. Run is sampled only in IDLE, WRITEBACK and TRAP.
- Reset mid-operation: state returns to IDLE immediately. Any pending RegWrite/PCWrite is dropped and never issued.
- Strobes are mutually exclusive across states. IRWrite and RegWrite are never high in the same cycle.

Decomposition:
- Shared package holds:
  - state encodings (3-bit localparams);
  - funct constants: FN_ADD=32, FN_SUB=34, FN_AND=36, FN_OR=37, FN_NOR=39, FN_SLT=42;
  - ALUOp constants: ALUOP_RTYPE=2'b10, ALUOP_ADD=2'b00.
- ALUControl reuses the same funct constants.
- One sub-module: mips_funct_legal, a combinational funct→legal check, unit-tested separately. Everything else stays in one FSM module.

Test Plan:
- Reset, Run=1, INSTRUCTION=32'h08011020 (funct 32) → IRWrite in cycle 1, ALUOp=2'b10 in cycle 3, RegWrite=PCWrite=1 in cycle 4, InstrCount=1, State back to FETCH in cycle 5.
- EXEC_CYCLES=3, funct 42 → ALUOp high for exactly 3 cycles; RegWrite in cycle 6; 6 cycles per instruction.
- INSTRUCTION=32'h00000025 then funct 6'h3F → first retires (InstrCount=1); second gives IllegalFunct pulse, PCWrite=1, RegWrite=0, InstrCount still 1.
- INSTRUCTION=32'h0 → State=HALT two cycles after FETCH, Halted=1. Toggling Run for 10 cycles leaves Halted=1 with no strobes. RESET_N low → Halted=0, State=IDLE.
- Run dropped during EXECUTE → WRITEBACK still issues RegWrite, then State=IDLE with no further IRWrite.
- RESET_N pulsed low asynchronously mid-EXECUTE (between clock edges) → outputs clear immediately, no RegWrite afterward. CNT_W=2 with 5 legal instructions → InstrCount saturates at 3.
